// File: rtl/gray_pkg.sv
// ---------------------------------------------------------------------------
// gray_pkg
//   Shared width constant and binary/Gray conversion helpers.
//   GRAY_W   : width of the converted value (fixed at 4)
//   bin2gray : reflected-binary encoding, bin ^ (bin >> 1)
//   gray2bin : inverse mapping, used by verification models
// ---------------------------------------------------------------------------
package gray_pkg;

    localparam int unsigned GRAY_W = 4;

    function automatic logic [GRAY_W-1:0] bin2gray(input logic [GRAY_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at and above it, so
    // the prefix XOR is built MSB-first.
    function automatic logic [GRAY_W-1:0] gray2bin(input logic [GRAY_W-1:0] gray);
        logic [GRAY_W-1:0] bin;
        int unsigned       idx;
        bin[GRAY_W-1] = gray[GRAY_W-1];
        for (int unsigned i = 1; i < GRAY_W; i++) begin
            idx      = GRAY_W - 1 - i;
            bin[idx] = bin[idx+1] ^ gray[idx];
        end
        return bin;
    endfunction

endpackage

// File: rtl/binary_to_gray.sv
// ---------------------------------------------------------------------------
// binary_to_gray
//   Registered 4-bit binary-to-Gray converter, one conversion per cycle,
//   one cycle of latency. Outputs come straight from flops.
//   clk         : system clock, rising edge
//   rst         : synchronous reset, active-high; clears outputs to 0000
//   b3..b0      : binary input bits (b3 = MSB), synchronous to clk
//   g3..g0      : registered Gray output bits (g3 = MSB)
// ---------------------------------------------------------------------------
module binary_to_gray
    import gray_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic b3,
    input  logic b2,
    input  logic b1,
    input  logic b0,
    output logic g3,
    output logic g2,
    output logic g1,
    output logic g0
);

    logic [GRAY_W-1:0] bin;
    logic [GRAY_W-1:0] gray_d;
    logic [GRAY_W-1:0] gray_q;

    assign bin = {b3, b2, b1, b0};

    always_comb begin
        gray_d = bin2gray(bin);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gray_q <= '0;
        end else begin
            gray_q <= gray_d;
        end
    end

    assign {g3, g2, g1, g0} = gray_q;

endmodule

// File: tb/tb_binary_to_gray.sv
module tb_binary_to_gray;
    import gray_pkg::*;

    logic clk;
    logic rst;
    logic b3, b2, b1, b0;
    logic g3, g2, g1, g0;

    int unsigned n_checks;
    int unsigned n_errors;

    logic [3:0] exp_prev;
    logic       have_prev;
    logic [3:0] g_last;
    logic [3:0] bv;
    logic       rv;

    // Hand-computed binary -> Gray table.
    localparam logic [3:0] GTAB [16] = '{
        4'b0000, 4'b0001, 4'b0011, 4'b0010,
        4'b0110, 4'b0111, 4'b0101, 4'b0100,
        4'b1100, 4'b1101, 4'b1111, 4'b1110,
        4'b1010, 4'b1011, 4'b1001, 4'b1000
    };

    binary_to_gray dut (
        .clk (clk),
        .rst (rst),
        .b3  (b3),
        .b2  (b2),
        .b1  (b1),
        .b0  (b0),
        .g3  (g3),
        .g2  (g2),
        .g1  (g1),
        .g0  (g0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] gout();
        return {g3, g2, g1, g0};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive at the falling edge, confirm the output has not moved before
    // the next rising edge, then check the registered result after it.
    task automatic apply(input logic [3:0] b, input logic r, input logic [3:0] exp, input string tag);
        @(negedge clk);
        {b3, b2, b1, b0} = b;
        rst = r;
        #1;
        if (have_prev) check({tag, "_hold"}, {28'd0, gout()}, {28'd0, exp_prev});
        @(posedge clk);
        #1;
        check(tag, {28'd0, gout()}, {28'd0, exp});
        exp_prev  = exp;
        have_prev = 1'b1;
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        have_prev = 1'b0;
        exp_prev  = '0;
        rst = 1'b1;
        {b3, b2, b1, b0} = 4'b1010;

        // Reset holds outputs at zero, release gives conversion of 1010.
        apply(4'b1010, 1'b1, 4'b0000, "reset1");
        apply(4'b1010, 1'b1, 4'b0000, "reset2");
        apply(4'b1010, 1'b0, 4'b1111, "reset_release");

        // Exhaustive sweep with single-bit-change check between steps.
        for (int i = 0; i < 16; i++) begin
            bv = 4'(i);
            apply(bv, 1'b0, GTAB[i], $sformatf("sweep_%0d", i));
            if (i > 0)
                check($sformatf("onebit_%0d", i), $countones(gout() ^ g_last), 32'd1);
            g_last = gout();
        end
        apply(4'b0000, 1'b0, 4'b0000, "wrap");
        check("onebit_wrap", $countones(gout() ^ g_last), 32'd1);

        // Spot values, each held for several cycles.
        for (int k = 0; k < 4; k++) apply(4'b0101, 1'b0, 4'b0111, "spot_0101");
        for (int k = 0; k < 4; k++) apply(4'b0110, 1'b0, 4'b0101, "spot_0110");
        for (int k = 0; k < 4; k++) apply(4'b1001, 1'b0, 4'b1101, "spot_1001");
        for (int k = 0; k < 4; k++) apply(4'b1011, 1'b0, 4'b1110, "spot_1011");

        // Reset mid-stream discards the in-flight value.
        apply(4'b1111, 1'b0, 4'b1000, "mid_pre");
        apply(4'b0011, 1'b1, 4'b0000, "mid_rst");
        apply(4'b0011, 1'b0, 4'b0010, "mid_post");

        // Back-to-back toggling.
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0) apply(4'b0000, 1'b0, 4'b0000, "toggle_lo");
            else            apply(4'b1111, 1'b0, 4'b1000, "toggle_hi");
        end

        // Random round trip with occasional reset pulses.
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            bv = 4'($urandom_range(0, 15));
            rv = ($urandom_range(0, 15) == 0);
            {b3, b2, b1, b0} = bv;
            rst = rv;
            @(posedge clk);
            #1;
            if (rv) check("rand_rst", {28'd0, gout()}, 32'd0);
            else    check("rand_roundtrip", {28'd0, gray2bin(gout())}, {28'd0, bv});
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
